// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extractor with valid/ready handshake.
// A main register (M) drives the outputs. A skid register (K) absorbs one
// extra entry, so in_ready can be derived from K alone and throughput stays
// at one entry per cycle.
// Optional feature macro: IMM_EXT_RVC_EN (ops 8-10 decode RVC immediates).
`timescale 1ns/1ps

module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_bad
);

  // Immediates are built 64 bits wide and then truncated to XLEN. For
  // XLEN=32 this gives the same low word, and no zero-width replications
  // are needed.
  logic [63:0]      wide;
  logic             bad_new;
  logic [XLEN-1:0]  imm_new;

  // Main (M) and skid (K) entry storage.
  logic             m_valid, k_valid;
  logic [XLEN-1:0]  m_imm, k_imm;
  logic [TAG_W-1:0] m_tag, k_tag;
  logic             m_bad, k_bad;

  logic accept;
  logic consume;

  // Opcode bits [6:0] never feed a 32-bit immediate. The XOR keeps them
  // visibly sunk instead of silently dangling.
  logic unused_inst;
  assign unused_inst = ^in_inst[6:0];

  // Combinational format decode of the incoming instruction word.
  always_comb begin
    wide    = 64'd0;
    bad_new = 1'b0;
    case (in_op)
      4'd0: wide = 64'd0;
      4'd1: wide = {{52{in_inst[31]}}, in_inst[31:20]};
      4'd2: wide = (XLEN == 32) ? {59'd0, in_inst[24:20]} : {58'd0, in_inst[25:20]};
      4'd3: wide = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      4'd4: wide = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
      4'd5: wide = {{32{in_inst[31]}}, in_inst[31:12], 12'd0};
      4'd6: wide = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};
`ifdef IMM_EXT_RVC_EN
      4'd8: wide = {{58{in_inst[12]}}, in_inst[12], in_inst[6:2]};
      4'd9: wide = {{52{in_inst[12]}}, in_inst[12], in_inst[8], in_inst[10:9],
                    in_inst[6], in_inst[7], in_inst[2], in_inst[11],
                    in_inst[5:3], 1'b0};
      4'd10: wide = {{55{in_inst[12]}}, in_inst[12], in_inst[6:5], in_inst[2],
                     in_inst[11:10], in_inst[4:3], 1'b0};
`endif
      default: begin
        wide    = 64'd0;
        bad_new = 1'b1;
      end
    endcase
  end

  assign imm_new = wide[XLEN-1:0];

  // Upper bits of the 64-bit scratch value are unused for narrow datapaths.
  generate
    if (XLEN < 64) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^wide[63:XLEN];
    end
  endgenerate

  // A flush cycle must not accept the entry that is presented alongside it.
  assign in_ready = !k_valid && !flush;
  assign accept   = in_valid && in_ready;
  assign consume  = m_valid && out_ready;

  // M/K occupancy and data movement. Flush wins over any accept or consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_imm   <= '0;
      m_tag   <= '0;
      m_bad   <= 1'b0;
      k_valid <= 1'b0;
      k_imm   <= '0;
      k_tag   <= '0;
      k_bad   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (consume) begin
      if (k_valid) begin
        // K is older than anything new; in_ready was low, so no accept.
        m_imm   <= k_imm;
        m_tag   <= k_tag;
        m_bad   <= k_bad;
        k_valid <= 1'b0;
      end else if (accept) begin
        m_imm <= imm_new;
        m_tag <= in_tag;
        m_bad <= bad_new;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (!m_valid) begin
      if (accept) begin
        m_valid <= 1'b1;
        m_imm   <= imm_new;
        m_tag   <= in_tag;
        m_bad   <= bad_new;
      end
    end else if (accept) begin
      // M is stalled; park the new entry in the skid register.
      k_valid <= 1'b1;
      k_imm   <= imm_new;
      k_tag   <= in_tag;
      k_bad   <= bad_new;
    end
  end

  assign out_valid = m_valid;
  assign out_imm   = m_imm;
  assign out_tag   = m_tag;
  assign out_bad   = m_bad;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: scoreboard bench for imm_ext_pipe. It drives XLEN=32 and
// XLEN=64 instances in lockstep. Expected entries are queued on acceptance,
// and per-instance monitors pop and compare them on each output handshake.
`timescale 1ns/1ps

module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_inst = 32'd0;
  logic [7:0]  in_tag = 8'd0;

  logic        rdy32, ov32, ob32;
  logic [31:0] oi32;
  logic [7:0]  ot32;
  logic        rdy64, ov64, ob64;
  logic [63:0] oi64;
  logic [7:0]  ot64;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        b;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] inst;
    logic [63:0] e32;
    logic [63:0] e64;
    logic        b;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  vec_t vecs[11];

  imm_ext_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy32), .in_op(in_op), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(oi32),
    .out_tag(ot32), .out_bad(ob32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy64), .in_op(in_op), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(oi64),
    .out_tag(ot64), .out_bad(ob64)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor for the 32-bit instance: compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov32 && out_ready) begin
      if (q32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut32_unexpected actual tag=%h required none", ot32);
      end else begin
        e = q32.pop_front();
        check("dut32_imm", {32'd0, oi32}, {32'd0, e.imm[31:0]});
        check("dut32_tag", {56'd0, ot32}, {56'd0, e.tag});
        check("dut32_bad", {63'd0, ob32}, {63'd0, e.b});
        $display("tx dut32 tag=%h imm=%h bad=%0b", ot32, oi32, ob32);
      end
    end
  end

  // Monitor for the 64-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov64 && out_ready) begin
      if (q64.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut64_unexpected actual tag=%h required none", ot64);
      end else begin
        e = q64.pop_front();
        check("dut64_imm", oi64, e.imm);
        check("dut64_tag", {56'd0, ot64}, {56'd0, e.tag});
        check("dut64_bad", {63'd0, ob64}, {63'd0, e.b});
        $display("tx dut64 tag=%h imm=%h bad=%0b", ot64, oi64, ob64);
      end
    end
  end

  // Present one entry (called just after a rising edge); returns the number
  // of cycles spent waiting for in_ready. Expected results are queued at the
  // accepting edge.
  task automatic send(input int idx, input logic [7:0] tag, output int waits);
    bit done;
    exp_t e;
    waits = 0;
    done = 0;
    in_valid = 1'b1;
    in_op = vecs[idx].op;
    in_inst = vecs[idx].inst;
    in_tag = tag;
    while (!done) begin
      @(negedge clk);
      if (rdy32 && rdy64) begin
        done = 1;
      end else begin
        waits++;
        if (waits >= 40) begin
          total++;
          bad++;
          $display("FAIL send_timeout actual=no_ready required=ready tag=%h", tag);
          in_valid = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
      end
    end
    e.tag = tag;
    e.b = vecs[idx].b;
    e.imm = {32'd0, vecs[idx].e32[31:0]};
    q32.push_back(e);
    e.imm = vecs[idx].e64;
    q64.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int w;
    vecs[0]  = '{4'd1,  32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{4'd4,  32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{4'd5,  32'h12345037, 64'h12345000, 64'h0000000012345000, 1'b0};
    vecs[3]  = '{4'd7,  32'h12345678, 64'h0,        64'h0,                1'b1};
    vecs[4]  = '{4'd2,  32'h03F00013, 64'h1F,       64'h3F,               1'b0};
    vecs[5]  = '{4'd5,  32'h80000037, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[6]  = '{4'd0,  32'hFFFFFFFF, 64'h0,        64'h0,                1'b0};
    vecs[7]  = '{4'd3,  32'h00A12423, 64'h8,        64'h8,                1'b0};
    vecs[8]  = '{4'd6,  32'h0080006F, 64'h8,        64'h8,                1'b0};
`ifdef IMM_EXT_RVC_EN
    vecs[9]  = '{4'd8,  32'h000010FD, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
`else
    vecs[9]  = '{4'd8,  32'h000010FD, 64'h0,        64'h0,                1'b1};
`endif
    vecs[10] = '{4'd15, 32'h0000FFFF, 64'h0,        64'h0,                1'b1};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid32", {63'd0, ov32}, 64'd0);
    check("rst_in_ready32", {63'd0, rdy32}, 64'd1);
    check("rst_out_imm32", {32'd0, oi32}, 64'd0);
    check("rst_out_tag32", {56'd0, ot32}, 64'd0);
    check("rst_out_bad32", {63'd0, ob32}, 64'd0);
    check("rst_out_valid64", {63'd0, ov64}, 64'd0);
    check("rst_out_imm64", oi64, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate stream through every format.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(i, 8'h10 + 8'(i), w);
      check("stream_no_stall", 64'(w), 64'd0);
    end
    drain();

    // Back-pressure: tags 1..5 with the consumer stalled.
    out_ready = 1'b0;
    send(0, 8'd1, w);
    send(1, 8'd2, w);
    @(negedge clk);
    check("bp_in_ready_low32", {63'd0, rdy32}, 64'd0);
    check("bp_in_ready_low64", {63'd0, rdy64}, 64'd0);
    check("bp_hold_tag_a", {56'd0, ot32}, 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_hold_tag_b", {56'd0, ot32}, 64'd1);
    check("bp_hold_valid", {63'd0, ov32}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2, 8'd3, w);
    check("bp_ready_rise_wait", 64'(w), 64'd1);
    send(4, 8'd4, w);
    send(5, 8'd5, w);
    drain();

    // Flush with M and K full and a new entry presented in the same cycle.
    out_ready = 1'b0;
    send(0, 8'h21, w);
    send(1, 8'h22, w);
    in_valid = 1'b1;
    in_op = 4'd1;
    in_inst = 32'h00100093;
    in_tag = 8'h77;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {63'd0, rdy32}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    check("flush_out_valid", {63'd0, ov32}, 64'd0);
    check("flush_in_ready_after", {63'd0, rdy32}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(7, 8'h23, w);
    drain();

    // Asynchronous reset while two entries are buffered.
    out_ready = 1'b0;
    send(0, 8'h31, w);
    send(1, 8'h32, w);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid32", {63'd0, ov32}, 64'd0);
    check("arst_in_ready32", {63'd0, rdy32}, 64'd1);
    check("arst_out_imm32", {32'd0, oi32}, 64'd0);
    check("arst_out_tag32", {56'd0, ot32}, 64'd0);
    check("arst_out_bad32", {63'd0, ob32}, 64'd0);
    check("arst_out_valid64", {63'd0, ov64}, 64'd0);
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2, 8'h33, w);
    @(negedge clk);
    check("arst_latency_valid", {63'd0, ov32}, 64'd1);
    @(posedge clk);
    #1;
    drain();

    check("end_queue32_empty", 64'(q32.size()), 64'd0);
    check("end_queue64_empty", 64'(q64.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
